spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  SPI mode-0 master (CPOL=0, CPHA=0), MSB first, active-low SSEL. Drives SCK/MOSI/SSEL into
//  spi_slave-class peripherals and captures MISO. Words come in on a valid/ready stream; the
//  TX_LAST flag ends a frame, so multi-word frames (e.g. 16-bit) keep SSEL low between words.
// PARAMETERS
//  DATA_W    8  bits per word (>=2)
//  HALF_DIV  4  CLK cycles per SCK half-period (>=1); SCK period = 2*HALF_DIV CLK cycles
// PORTS
//  CLK       in   1       system clock; all logic on posedge CLK
//  RST       in   1       synchronous reset, active-high
//  TX_DATA   in   DATA_W  word to send, MSB first
//  TX_LAST   in   1       word is the last of the frame (SSEL released after it)
//  TX_VALID  in   1       TX_DATA/TX_LAST valid
//  TX_READY  out  1       block accepts a word; transfer on TX_VALID&TX_READY
//  RX_DATA   out  DATA_W  word captured from MISO
//  RX_VALID  out  1       one-cycle pulse, RX_DATA valid
//  BUSY      out  1       high from accept until return to IDLE
//  SCK       out  1       serial clock, idle low
//  MOSI      out  1       serial data out
//  MISO      in   1       serial data in
//  SSEL      out  1       slave select, active low
// BEHAVIOUR
//  Reset (RST=1 at an edge): state->IDLE, SCK=0, SSEL=1, MOSI=0, RX_DATA=0, RX_VALID=0, BUSY=0,
//   bit/divider counters=0. TX_READY=0 while RST=1. Reset mid-word aborts at once: next edge
//   SCK=0 and SSEL=1, no RX_VALID. All SPI outputs are registered (glitch-free).
//  States: IDLE, SETUP, HIGH, LOW, NEXT, HOLD, DESEL.
//  IDLE: TX_READY=1, SSEL=1, SCK=0. On handshake (cycle 0): load shifter, latch TX_LAST.
//   Cycle 1: SSEL=0, MOSI=TX_DATA[DATA_W-1], BUSY=1, enter SETUP.
//  SETUP: HALF_DIV cycles with SCK=0, then SCK=1 (first rise at cycle 1+HALF_DIV) -> HIGH.
//  HIGH: HALF_DIV cycles. MISO sampled into rx shifter in the last CLK cycle of HIGH.
//   Then SCK=0 (falling edge) and MOSI takes the next bit on that same edge -> LOW.
//  LOW: HALF_DIV cycles, then SCK=1 -> HIGH. Bit counter counts falling edges.
//  At the DATA_W-th falling edge: RX_DATA=rx shifter, RX_VALID=1 for that cycle only.
//   MOSI holds the last bit. Not last -> NEXT; last -> HOLD.
//  NEXT: SSEL=0, SCK=0, TX_READY=1, waits without limit. On handshake: load the word and
//   put its MSB on MOSI on the next edge -> LOW (rise after HALF_DIV cycles, same as SETUP).
//  HOLD: HALF_DIV cycles with SSEL=0, SCK=0, then SSEL=1 -> DESEL.
//  DESEL: HALF_DIV cycles with SSEL=1 (minimum deselect time), then BUSY=0 -> IDLE.
//  TX_READY is 0 in SETUP/HIGH/LOW/HOLD/DESEL. TX_VALID there is ignored and not consumed.
//  Exactly DATA_W SCK rises per word, and no SCK edge while SSEL=1.
//  HALF_DIV=1 is legal: SCK toggles every CLK cycle.
//  Divider and bit counters are sized for HALF_DIV and DATA_W exactly, with no wrap inside a word.
// TESTING
//  T1 loopback (MISO=MOSI), HALF_DIV=2: send 0xA5 with LAST=1 -> 8 SCK rises, MOSI bits 1,0,1,0,
//     0,1,0,1 stable at each rise, RX_DATA=0xA5 with one RX_VALID pulse, SSEL low->high once.
//  T2 frame of 0xE3 (LAST=0) then 0x55 (LAST=1), with spi_slave attached -> SSEL stays low across
//     16 rises; the slave receives 1110001101010101; two RX_VALID pulses.
//  T3 bench drives MISO with 0x3C (changing after each falling edge) while sending 0x00 ->
//     RX_DATA=0x3C.
//  T4 after a non-last word, hold TX_VALID low for 20 cycles -> stays in NEXT with SSEL=0, SCK=0,
//     TX_READY=1. A later word finishes the frame correctly.
//  T5 RST=1 for 1 cycle after the 3rd SCK rise -> next cycle SCK=0, SSEL=1, BUSY=0, no RX_VALID.
//     A new 0x81 transfer then completes correctly.
//  T6 TX_VALID held high with changing data during a transfer -> only handshaked words are sent,
//     and the TX_READY low periods match the state table.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, active-low slave select.
// Words arrive on a valid/ready stream; TX_LAST closes the frame and releases SSEL.
module spi_master #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HALF_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_LAST,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              BUSY,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SSEL
);

  localparam int unsigned      DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned      BIT_W    = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    NEXT,
    HOLD,
    DESEL
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-2:0]   rx_sh_q, rx_sh_d;
  logic                last_q, last_d;
  logic                sck_q, sck_d;
  logic                ssel_q, ssel_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                busy_q, busy_d;
  logic                div_end;
  logic [DATA_W-1:0]   rx_word;

  assign div_end = (div_q == DIV_LAST);
  // MISO joins the partial word; only DATA_W-1 bits need storing between samples.
  assign rx_word = {rx_sh_q, MISO};

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          tx_sh_d = {TX_DATA[DATA_W-2:0], 1'b0};
          mosi_d  = TX_DATA[DATA_W-1];
          last_d  = TX_LAST;
          ssel_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP, LOW: begin
        if (div_end) begin
          sck_d   = 1'b1;
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_d   = '0;
          sck_d   = 1'b0;
          rx_sh_d = rx_word[DATA_W-2:0];
          if (bit_q == BIT_LAST) begin
            bit_d      = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            state_d    = last_q ? HOLD : NEXT;
          end else begin
            bit_d   = bit_q + 1'b1;
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            state_d = LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      NEXT: begin
        if (TX_VALID) begin
          tx_sh_d = {TX_DATA[DATA_W-2:0], 1'b0};
          mosi_d  = TX_DATA[DATA_W-1];
          last_d  = TX_LAST;
          div_d   = '0;
          state_d = LOW;
        end
      end
      HOLD: begin
        if (div_end) begin
          ssel_d  = 1'b1;
          div_d   = '0;
          state_d = DESEL;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DESEL: begin
        if (div_end) begin
          busy_d  = 1'b0;
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      ssel_q     <= ssel_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_READY = ~RST & ((state_q == IDLE) | (state_q == NEXT));
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign BUSY     = busy_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;
  assign SSEL     = ssel_q;

endmodule
